dmem_responder: RTL

- Responder end of the core's data-memory interface. The core issues load/store requests; this block accepts them, inserts programmable wait states, and returns load data or completes the store.
- Word-organised storage with RV32I byte/halfword lane handling and load sign/zero extension.
- Sits beside the instruction memory in the top level and replaces the zero-wait data memory when stalls must be exercised.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_lane_unit.sv | 65 ++++++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t : responder FSM states
//   F3_*    : RV32I load/store width codes (funct3)
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane logic for RV32I loads and stores.
//   addr_lo_i   : byte offset within the word (addr[1:0])
//   funct3_i    : width code
//   is_store_i  : access is a store (LBU/LHU codes are illegal for stores)
//   wdata_i     : right-aligned store data
//   rword_i     : storage word being read
//   be_o        : store byte-enable mask
//   wdata_sh_o  : store data shifted into its lanes
//   rdata_ext_o : extracted and extended load data
//   fault_o     : misaligned access or illegal funct3
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_sh_o,
  output logic [31:0] rdata_ext_o,
  output logic        fault_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = rword_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Aligned accesses only reach the lanes, so a plain byte shift places SB/SH/SW data.
  assign wdata_sh_o = wdata_i << {addr_lo_i, 3'b000};

  always_comb begin
    be_o        = 4'b0000;
    rdata_ext_o = 32'h0;
    fault_o     = 1'b0;
    unique case (funct3_i)
      F3_B: begin
        be_o        = 4'b0001 << addr_lo_i;
        rdata_ext_o = {{24{rbyte[7]}}, rbyte};
      end
      F3_H: begin
        be_o        = 4'b0011 << {addr_lo_i[1], 1'b0};
        rdata_ext_o = {{16{rhalf[15]}}, rhalf};
        fault_o     = addr_lo_i[0];
      end
      F3_W: begin
        be_o        = 4'b1111;
        rdata_ext_o = rword_i;
        fault_o     = (addr_lo_i != 2'b00);
      end
      F3_BU: begin
        rdata_ext_o = {24'h0, rbyte};
        fault_o     = is_store_i;
      end
      F3_HU: begin
        rdata_ext_o = {16'h0, rhalf};
        fault_o     = is_store_i | addr_lo_i[0];
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states.
//   clk, rst (sync, active-low)
//   req_read_en/req_write_en/req_addr/req_wdata/req_funct3 : request, taken when req_ready
//   req_ready  : idle and able to accept
//   resp_valid : one-cycle completion pulse; resp_fault qualifies it
//   resp_rdata : extended load data, 0 for stores and faults
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned B_WIDTH     = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_read_en,
  input  logic               req_write_en,
  input  logic [31:0]        req_addr,
  input  logic [B_WIDTH-1:0] req_wdata,
  input  logic [2:0]         req_funct3,
  output logic               req_ready,
  output logic               resp_valid,
  output logic [B_WIDTH-1:0] resp_rdata,
  output logic               resp_fault
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [B_WIDTH-1:0] mem_q [DEPTH_WORDS];

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic [AW+1:0]      addr_q;
  logic [B_WIDTH-1:0] wdata_q;
  logic [2:0]         f3_q;
  logic               wr_q;
  logic               flt_q;
  logic               ready_q, valid_q, fault_q;
  logic [B_WIDTH-1:0] rdata_q;

  // Upper address bits wrap away.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  // In IDLE the lane unit looks at the live request (needed for the fault latch and for
  // the zero-wait response); afterwards it looks at the latched transaction.
  logic               idle;
  logic [AW+1:0]      cur_addr;
  logic [B_WIDTH-1:0] cur_wdata;
  logic [2:0]         cur_f3;
  logic               cur_wr;
  logic               cur_fault;
  logic [3:0]         be;
  logic [B_WIDTH-1:0] wdata_sh, rdata_ext;
  logic               lane_fault;

  assign idle      = (state_q == IDLE);
  assign cur_addr  = idle ? req_addr[AW+1:0] : addr_q;
  assign cur_wdata = idle ? req_wdata : wdata_q;
  assign cur_f3    = idle ? req_funct3 : f3_q;
  assign cur_wr    = idle ? req_write_en : wr_q;
  assign cur_fault = idle ? ((req_read_en & req_write_en) | lane_fault) : flt_q;

  dmem_lane_unit u_lane (
    .addr_lo_i   (cur_addr[1:0]),
    .funct3_i    (cur_f3),
    .is_store_i  (cur_wr),
    .wdata_i     (cur_wdata),
    .rword_i     (mem_q[cur_addr[AW+1:2]]),
    .be_o        (be),
    .wdata_sh_o  (wdata_sh),
    .rdata_ext_o (rdata_ext),
    .fault_o     (lane_fault)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_read_en | req_write_en) begin
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            f3_q    <= req_funct3;
            wr_q    <= req_write_en;
            flt_q   <= cur_fault;
            ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state_q <= RESP;
              valid_q <= 1'b1;
              fault_q <= cur_fault;
              rdata_q <= (cur_fault | cur_wr) ? '0 : rdata_ext;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            fault_q <= cur_fault;
            rdata_q <= (cur_fault | cur_wr) ? '0 : rdata_ext;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Store commit on the edge leaving RESP; a reset on that edge drops it.
  always_ff @(posedge clk) begin
    if (rst && state_q == RESP && wr_q && !flt_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_fault = fault_q;

endmodule
